// File: rtl/traffic_phase_scheduler.sv
// Chooses the next NS/EW phase and its green time from vehicle demand and pedestrian
// requests, then hands it to the light FSM through a valid/ready command.
module traffic_phase_scheduler #(
    parameter int unsigned BASE_GREEN    = 100,
    parameter int unsigned PER_VEHICLE   = 20,
    parameter int unsigned MAX_GREEN     = 300,
    parameter int unsigned PED_MIN_GREEN = 200,
    parameter int unsigned TEST_GREEN    = 10,
    parameter int unsigned MAX_HOLDS     = 3
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic [2:0]  vcount_northbound_i,
    input  logic [2:0]  vcount_southbound_i,
    input  logic [2:0]  vcount_eastbound_i,
    input  logic [2:0]  vcount_westbound_i,
    input  logic        ped_button_ns_i,
    input  logic        ped_button_ew_i,
    input  logic        test_mode_i,
    input  logic        phase_ready_i,
    input  logic        phase_done_i,
    output logic        phase_valid_o,
    output logic        phase_sel_o,
    output logic [15:0] green_time_o,
    output logic        ped_walk_o,
    output logic        ped_pending_ns_o,
    output logic        ped_pending_ew_o,
    output logic [15:0] phase_count_o
);

    localparam int unsigned HW = $clog2(MAX_HOLDS + 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_DECIDE,
        ST_ISSUE,
        ST_ACTIVE
    } state_t;

    state_t        state_reg, state_next;
    logic          cur_dir_reg;
    logic          first_reg;
    logic [HW-1:0] hold_count_reg;
    logic          pend_ns_reg, pend_ew_reg;
    logic          phase_valid_reg, phase_sel_reg, ped_walk_reg;
    logic [15:0]   green_time_reg, phase_count_reg;

    logic [3:0]    dem_ns, dem_ew, dem_cur, dem_oth, dem_sel;
    logic          oth_pending, switch_dir;
    logic          sel_next, walk_next;
    logic [HW-1:0] hold_next;
    logic [15:0]   g_calc, green_next;
    logic          accept, consume_ns, consume_ew;

    // State register
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg <= ST_INIT;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_INIT:   state_next = ST_DECIDE;
            ST_DECIDE: state_next = ST_ISSUE;
            ST_ISSUE:  if (phase_ready_i) state_next = ST_ACTIVE;
            ST_ACTIVE: if (phase_done_i) state_next = ST_DECIDE;
            default:   state_next = ST_INIT;
        endcase
    end

    // Decision logic: direction, hold counter, green time and walk flag
    always_comb begin
        dem_ns      = {1'b0, vcount_northbound_i} + {1'b0, vcount_southbound_i};
        dem_ew      = {1'b0, vcount_eastbound_i} + {1'b0, vcount_westbound_i};
        dem_cur     = cur_dir_reg ? dem_ew : dem_ns;
        dem_oth     = cur_dir_reg ? dem_ns : dem_ew;
        oth_pending = cur_dir_reg ? pend_ns_reg : pend_ew_reg;

        switch_dir = oth_pending ||
                     ((dem_oth != 4'd0) &&
                      ((dem_oth >= dem_cur) || (hold_count_reg >= HW'(MAX_HOLDS))));

        // The very first decision after reset always serves NS and starts a fresh hold run
        if (first_reg) begin
            sel_next  = 1'b0;
            hold_next = '0;
        end else if (switch_dir) begin
            sel_next  = ~cur_dir_reg;
            hold_next = '0;
        end else begin
            sel_next  = cur_dir_reg;
            hold_next = (hold_count_reg >= HW'(MAX_HOLDS)) ? HW'(MAX_HOLDS)
                                                           : hold_count_reg + HW'(1);
        end

        dem_sel   = sel_next ? dem_ew : dem_ns;
        walk_next = sel_next ? pend_ew_reg : pend_ns_reg;

        g_calc = 16'(BASE_GREEN) + 16'(dem_sel) * 16'(PER_VEHICLE);
        if (g_calc > 16'(MAX_GREEN)) begin
            green_next = 16'(MAX_GREEN);
        end else begin
            green_next = g_calc;
        end
        if (walk_next && (green_next < 16'(PED_MIN_GREEN))) begin
            green_next = 16'(PED_MIN_GREEN);
        end
        if (test_mode_i) begin
            green_next = 16'(TEST_GREEN);
        end
    end

    assign accept     = (state_reg == ST_ISSUE) && phase_ready_i;
    assign consume_ns = accept && ped_walk_reg && !phase_sel_reg;
    assign consume_ew = accept && ped_walk_reg && phase_sel_reg;

    // Pedestrian latches: a press coinciding with the consuming accept survives
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pend_ns_reg <= 1'b0;
            pend_ew_reg <= 1'b0;
        end else begin
            pend_ns_reg <= (pend_ns_reg & ~consume_ns) | ped_button_ns_i;
            pend_ew_reg <= (pend_ew_reg & ~consume_ew) | ped_button_ew_i;
        end
    end

    // Command and bookkeeping registers
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cur_dir_reg     <= 1'b0;
            first_reg       <= 1'b1;
            hold_count_reg  <= '0;
            phase_valid_reg <= 1'b0;
            phase_sel_reg   <= 1'b0;
            green_time_reg  <= '0;
            ped_walk_reg    <= 1'b0;
            phase_count_reg <= '0;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    cur_dir_reg <= 1'b0;
                end
                ST_DECIDE: begin
                    phase_valid_reg <= 1'b1;
                    phase_sel_reg   <= sel_next;
                    green_time_reg  <= green_next;
                    ped_walk_reg    <= walk_next;
                    cur_dir_reg     <= sel_next;
                    hold_count_reg  <= hold_next;
                    first_reg       <= 1'b0;
                end
                ST_ISSUE: begin
                    if (phase_ready_i) begin
                        phase_valid_reg <= 1'b0;
                        phase_count_reg <= phase_count_reg + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign phase_valid_o    = phase_valid_reg;
    assign phase_sel_o      = phase_sel_reg;
    assign green_time_o     = green_time_reg;
    assign ped_walk_o       = ped_walk_reg;
    assign ped_pending_ns_o = pend_ns_reg;
    assign ped_pending_ew_o = pend_ew_reg;
    assign phase_count_o    = phase_count_reg;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler: walks through the phase sequence with
// hand-computed directions, green times, pedestrian flags and counts.
module tb_traffic_phase_scheduler;

    logic        clock_i = 1'b0;
    logic        reset_n_i;
    logic [2:0]  vcount_northbound_i, vcount_southbound_i;
    logic [2:0]  vcount_eastbound_i, vcount_westbound_i;
    logic        ped_button_ns_i, ped_button_ew_i, test_mode_i;
    logic        phase_ready_i, phase_done_i;
    logic        phase_valid_o, phase_sel_o, ped_walk_o;
    logic        ped_pending_ns_o, ped_pending_ew_o;
    logic [15:0] green_time_o, phase_count_o;

    int checks   = 0;
    int failures = 0;

    traffic_phase_scheduler dut (
        .clock_i             (clock_i),
        .reset_n_i           (reset_n_i),
        .vcount_northbound_i (vcount_northbound_i),
        .vcount_southbound_i (vcount_southbound_i),
        .vcount_eastbound_i  (vcount_eastbound_i),
        .vcount_westbound_i  (vcount_westbound_i),
        .ped_button_ns_i     (ped_button_ns_i),
        .ped_button_ew_i     (ped_button_ew_i),
        .test_mode_i         (test_mode_i),
        .phase_ready_i       (phase_ready_i),
        .phase_done_i        (phase_done_i),
        .phase_valid_o       (phase_valid_o),
        .phase_sel_o         (phase_sel_o),
        .green_time_o        (green_time_o),
        .ped_walk_o          (ped_walk_o),
        .ped_pending_ns_o    (ped_pending_ns_o),
        .ped_pending_ew_o    (ped_pending_ew_o),
        .phase_count_o       (phase_count_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    // Advance one rising edge; inputs are driven and outputs sampled 1ns after it
    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic set_counts(input int n, input int s, input int e, input int w);
        vcount_northbound_i = 3'(n);
        vcount_southbound_i = 3'(s);
        vcount_eastbound_i  = 3'(e);
        vcount_westbound_i  = 3'(w);
    endtask

    task automatic pulse_done();
        phase_done_i = 1'b1;
        tick();
        phase_done_i = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (phase_valid_o) break;
            tick();
        end
        check_eq({tag, "_valid"}, 32'(phase_valid_o), 1);
    endtask

    // Check the issued command, then let it be accepted and check the count
    task automatic expect_phase(input string tag, input int sel, input int green,
                                input int walk, input int count_after);
        wait_valid(tag);
        check_eq({tag, "_sel"}, 32'(phase_sel_o), sel);
        check_eq({tag, "_green"}, 32'(green_time_o), green);
        check_eq({tag, "_walk"}, 32'(ped_walk_o), walk);
        phase_ready_i = 1'b1;
        tick();
        check_eq({tag, "_count"}, 32'(phase_count_o), count_after);
        check_eq({tag, "_valid_drop"}, 32'(phase_valid_o), 0);
    endtask

    initial begin
        reset_n_i       = 1'b0;
        set_counts(0, 0, 0, 0);
        ped_button_ns_i = 1'b0;
        ped_button_ew_i = 1'b0;
        test_mode_i     = 1'b0;
        phase_ready_i   = 1'b1;
        phase_done_i    = 1'b0;
        tick();
        tick();
        check_eq("rst_valid", 32'(phase_valid_o), 0);
        check_eq("rst_green", 32'(green_time_o), 0);
        check_eq("rst_count", 32'(phase_count_o), 0);
        reset_n_i = 1'b1;

        // First phase: INIT then DECIDE, valid after two edges
        tick();
        check_eq("p1_valid_early", 32'(phase_valid_o), 0);
        tick();
        check_eq("p1_valid_edge2", 32'(phase_valid_o), 1);
        expect_phase("p1", 0, 100, 0, 1);

        // One westbound vehicle pulls service to EW; hold ready low for 5 cycles
        set_counts(0, 0, 0, 1);
        phase_ready_i = 1'b0;
        pulse_done();
        wait_valid("p2");
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("p2_hold_valid", 32'(phase_valid_o), 1);
            check_eq("p2_hold_sel", 32'(phase_sel_o), 1);
            check_eq("p2_hold_green", 32'(green_time_o), 120);
            check_eq("p2_hold_count", 32'(phase_count_o), 1);
        end
        expect_phase("p2", 1, 120, 0, 2);

        // NS pedestrian press during the EW phase forces NS with a 200-cycle walk
        ped_button_ns_i = 1'b1;
        tick();
        ped_button_ns_i = 1'b0;
        check_eq("p3_pend_ns", 32'(ped_pending_ns_o), 1);
        set_counts(0, 0, 0, 0);
        pulse_done();
        wait_valid("p3_pre");
        check_eq("p3_pend_in_issue", 32'(ped_pending_ns_o), 1);
        expect_phase("p3", 0, 200, 1, 3);
        check_eq("p3_pend_cleared", 32'(ped_pending_ns_o), 0);

        // Heavy NS demand: three saturated re-issues, then forced switch to EW
        set_counts(7, 7, 1, 0);
        pulse_done();
        expect_phase("p4_hold1", 0, 300, 0, 4);
        pulse_done();
        expect_phase("p4_hold2", 0, 300, 0, 5);
        pulse_done();
        expect_phase("p4_hold3", 0, 300, 0, 6);
        pulse_done();
        expect_phase("p4_switch", 1, 120, 0, 7);

        // Test mode overrides the demand-based green time
        test_mode_i = 1'b1;
        pulse_done();
        expect_phase("p5_test", 0, 10, 0, 8);
        test_mode_i = 1'b0;

        // Reset while a command is waiting in ISSUE, with an EW request latched
        set_counts(0, 0, 0, 0);
        ped_button_ew_i = 1'b1;
        tick();
        ped_button_ew_i = 1'b0;
        check_eq("p6_pend_ew", 32'(ped_pending_ew_o), 1);
        phase_ready_i = 1'b0;
        pulse_done();
        wait_valid("p6_pre");
        #2;
        reset_n_i = 1'b0;
        #1;
        check_eq("p6_rst_valid", 32'(phase_valid_o), 0);
        check_eq("p6_rst_sel", 32'(phase_sel_o), 0);
        check_eq("p6_rst_green", 32'(green_time_o), 0);
        check_eq("p6_rst_walk", 32'(ped_walk_o), 0);
        check_eq("p6_rst_pend_ew", 32'(ped_pending_ew_o), 0);
        check_eq("p6_rst_count", 32'(phase_count_o), 0);
        tick();
        reset_n_i = 1'b1;
        phase_ready_i = 1'b1;
        tick();
        tick();
        expect_phase("p7_after_rst", 0, 100, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
- Decides which direction pair (NS or EW) the traffic light FSM serves next, and for how long.
- Sits between the vehicle-count sensors and pedestrian buttons on one side and the light FSM on the other.
- Issues one phase command per phase through a valid/ready handshake, then waits for the FSM to report that the phase (green plus yellow) is finished.
- Computes green time from demand, latches pedestrian requests, and prevents starvation of the lighter direction.

Parameters:
BASE_GREEN, 100, minimum green time in clock cycles
PER_VEHICLE, 20, green cycles added per waiting vehicle in the served pair
MAX_GREEN, 300, saturation ceiling for computed green time
PED_MIN_GREEN, 200, minimum green time when a pedestrian walk is granted
TEST_GREEN, 10, fixed green time when test_mode_i=1
MAX_HOLDS, 3, consecutive re-issues of the same direction before a forced switch

Ports:
clock_i  in  1  system clock
reset_n_i  in  1  asynchronous active-low reset
vcount_northbound_i  in  3  vehicles waiting northbound
vcount_southbound_i  in  3  vehicles waiting southbound
vcount_eastbound_i  in  3  vehicles waiting eastbound
vcount_westbound_i  in  3  vehicles waiting westbound
ped_button_ns_i  in  1  NS pedestrian button (level, may be 1 cycle)
ped_button_ew_i  in  1  EW pedestrian button
test_mode_i  in  1  forces TEST_GREEN
phase_ready_i  in  1  light FSM accepts the phase command
phase_done_i  in  1  1-cycle pulse: current phase finished (yellow ended)
phase_valid_o  out  1  phase command valid
phase_sel_o  out  1  0=NS, 1=EW
green_time_o  out  16  green duration for the issued phase
ped_walk_o  out  1  walk granted with the issued phase
ped_pending_ns_o  out  1  latched NS pedestrian request
ped_pending_ew_o  out  1  latched EW pedestrian request
phase_count_o  out  16  accepted phase commands, wraps at 65535->0

Behaviour:
- Clock and reset: single clock domain, rising edge. reset_n_i is asynchronous and active-low.
- Reset values: phase_valid_o=0, phase_sel_o=0, green_time_o=0, ped_walk_o=0, both pending flags=0, phase_count_o=0, hold_count=0, state=INIT.
- A reset assertion mid-phase aborts immediately; any pending requests are lost.
- State INIT: first edge after reset release -> DECIDE, with current direction forced to NS (first phase is always NS).
- State DECIDE (one cycle):
  - Samples the counts and computes the next direction, green time and walk flag.
  - Next edge: registers these onto the outputs, sets phase_valid_o=1, goes to ISSUE.
- State ISSUE:
  - phase_valid_o, phase_sel_o, green_time_o and ped_walk_o are held stable until phase_ready_i=1 is sampled.
  - On that edge: phase_valid_o=0, phase_count_o+1, the served direction's pending flag is cleared if ped_walk_o=1, -> ACTIVE.
- State ACTIVE: waits for phase_done_i. phase_done_i=1 sampled at edge k -> DECIDE at k, phase_valid_o=1 after edge k+1. phase_done_i outside ACTIVE is ignored.
- Demand widths: dem_ns = N+S and dem_ew = E+W, each 4 bits, range 0..14.
- Direction decision (cur = last served direction, oth = the other), first match wins:
  1. oth pedestrian pending -> switch.
  2. dem_oth>0 and (dem_oth>=dem_cur or hold_count>=MAX_HOLDS) -> switch.
  3. Otherwise stay on cur.
- hold_count: cleared on a switch; incremented on a stay, saturating at MAX_HOLDS.
- Green time:
  - g = BASE_GREEN + dem_sel*PER_VEHICLE, computed in 16 bits and saturated to MAX_GREEN.
  - If a walk is granted, g = max(g, PED_MIN_GREEN).
  - If test_mode_i=1, g = TEST_GREEN regardless.
- ped_walk_o = pending flag of the selected direction, sampled in DECIDE.
- Pedestrian latches: pending_next = (pending & ~consume) | button. A press in the same cycle as the consuming accept stays pending.
- The button is accepted in any state, including INIT and ISSUE.

Test Plan:
- Reset release, all counts 0, phase_ready_i=1 -> phase_valid_o=1 two edges after release, phase_sel_o=0, green_time_o=100, ped_walk_o=0, phase_count_o=1 after the accept.
- Counts N=0, S=0, E=0, W=1, phase_done_i pulse -> phase_sel_o=1, green_time_o=120.
- Hold phase_ready_i=0 for 5 cycles -> command holds stable, phase_count_o unchanged; it increments only on the ready edge.
- During an EW phase, 1-cycle ped_button_ns_i -> ped_pending_ns_o=1; next phase NS, ped_walk_o=1, green_time_o=200; pending clears on accept.
- N=7, S=7, E=1, W=0, repeated done pulses:
  - NS is re-issued 3 times with green_time_o=300 (380 saturated).
  - The 4th decision switches to EW with green 120.
- test_mode_i=1 with N=7 -> green_time_o=10.
- Assert reset_n_i during ISSUE -> all outputs return to reset values asynchronously; the next command after release is NS.
